// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Round-robin pick searches from ptr with an explicit modulo-N wrap.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    SEND,
    WAIT
  } state_t;

  localparam logic [3:0] HDR_NIB = 4'hA;

  function automatic logic [2:0] rr_pick(
    input logic [7:0] valid,
    input logic [2:0] ptr,
    input int         n
  );
    logic [2:0] win;
    int         idx;
    win = ptr;
    // Walk farthest-first so the nearest valid channel wins last.
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) win = 3'(idx);
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART transmit signals shared by the arbiter.
// slave = arbiter side, master = environment side.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N*8-1:0] ipReqData;
  logic [N-1:0]   ipReqValid;
  logic [N-1:0]   ipReqLast;
  logic [N-1:0]   opReqReady;
  logic [7:0]     opTxData;
  logic           opTxSend;
  logic           ipTxBusy;
  logic [N-1:0]   opGrant;
  logic           opActive;

  modport slave (
    input  ipReqData, ipReqValid, ipReqLast, ipTxBusy,
    output opReqReady, opTxData, opTxSend, opGrant, opActive
  );

  modport master (
    output ipReqData, ipReqValid, ipReqLast, ipTxBusy,
    input  opReqReady, opTxData, opTxSend, opGrant, opActive
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin pick of the first valid channel from ptr.
// ptr moves past the released owner when update pulses.
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  valid,
  input  logic          update,
  input  logic [PW-1:0] grant_idx,
  output logic [PW-1:0] pick,
  output logic          any
);

  logic [PW-1:0] ptr;

  assign pick = PW'(rr_pick(8'(valid), 3'(ptr), N));
  assign any  = |valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (update) begin
      if (grant_idx == PW'(N - 1))
        ptr <= '0;
      else
        ptr <= grant_idx + PW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX between N byte-stream requesters.
// Define UART_TX_ARBITER_HEADER_EN to prefix packets with a channel header.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N            = 4,
  parameter bit LOCK_PACKETS = 1'b1
) (
  input  logic              ipClk,
  input  logic              ipReset,
  uart_tx_arbiter_if.slave  bus
);

  localparam int PW = $clog2(N);

  state_t        state;
  logic [PW-1:0] gidx;
  logic [PW-1:0] pick;
  logic          any;
  logic          last_q;
  logic          hdr_q;
  logic          release_now;

  assign release_now = (state == WAIT) && !bus.ipTxBusy &&
                       !hdr_q && (last_q || !LOCK_PACKETS);

  rr_arbiter #(
    .N  (N),
    .PW (PW)
  ) u_rr (
    .clk       (ipClk),
    .rst       (ipReset),
    .valid     (bus.ipReqValid),
    .update    (release_now),
    .grant_idx (gidx),
    .pick      (pick),
    .any       (any)
  );

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state          <= IDLE;
      gidx           <= '0;
      last_q         <= 1'b0;
      hdr_q          <= 1'b0;
      bus.opGrant    <= '0;
      bus.opActive   <= 1'b0;
      bus.opReqReady <= '0;
      bus.opTxData   <= '0;
      bus.opTxSend   <= 1'b0;
    end else begin
      bus.opReqReady <= '0;
      unique case (state)
        IDLE: begin
          // Busy check also covers reset released mid-frame.
          if (any && !bus.ipTxBusy) begin
            gidx         <= pick;
            bus.opGrant  <= N'(1) << pick;
            bus.opActive <= 1'b1;
`ifdef UART_TX_ARBITER_HEADER_EN
            state        <= HDR;
`else
            state        <= LOAD;
`endif
          end
        end
`ifdef UART_TX_ARBITER_HEADER_EN
        HDR: begin
          bus.opTxData <= {HDR_NIB, 1'b0, 3'(gidx)};
          hdr_q        <= 1'b1;
          state        <= SEND;
        end
`endif
        LOAD: begin
          if (bus.ipReqValid[gidx]) begin
            bus.opTxData   <= bus.ipReqData[int'(gidx)*8 +: 8];
            bus.opReqReady <= N'(1) << gidx;
            last_q         <= bus.ipReqLast[gidx];
            state          <= SEND;
          end
        end
        SEND: begin
          bus.opTxSend <= 1'b1;
          if (bus.ipTxBusy && bus.opTxSend) begin
            bus.opTxSend <= 1'b0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.ipTxBusy) begin
            if (hdr_q) begin
              hdr_q <= 1'b0;
              state <= LOAD;
            end else if (last_q || !LOCK_PACKETS) begin
              bus.opGrant  <= '0;
              bus.opActive <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model.
// Expected byte streams include headers when UART_TX_ARBITER_HEADER_EN is set.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(
    .N            (N),
    .LOCK_PACKETS (1'b1)
  ) dut (
    .ipClk   (clk),
    .ipReset (rst),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [8:0] q3[$];
  int rp[4] = '{0, 0, 0, 0};

  logic [7:0] sent[$];
  logic [7:0] expq[$];
  int base = 0;

  int rdy_cnt[4] = '{0, 0, 0, 0};
  int multi_rdy = 0;
  int send_busy = 0;
  int send_hi   = 0;

  int   busy_len   = 8;
  bit   busy_force = 1'b0;
  logic mb  = 1'b0;
  int   dly = 0;
  int   bc  = 0;
  logic [7:0] cap = '0;

  assign bus.ipTxBusy = mb | busy_force;

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic logic [8:0] qget(input int k, input int r);
    case (k)
      0: return q0[r];
      1: return q1[r];
      2: return q2[r];
      default: return q3[r];
    endcase
  endfunction

  // Requesters: present the byte at rp, advance on a ready pulse.
  always @(negedge clk) begin : drv
    for (int k = 0; k < 4; k++) begin
      int r;
      logic [8:0] e;
      r = rp[k] + (bus.opReqReady[k] ? 1 : 0);
      rp[k] <= r;
      if (r < qsize(k)) begin
        e = qget(k, r);
        bus.ipReqValid[k]        <= 1'b1;
        bus.ipReqLast[k]         <= e[8];
        bus.ipReqData[8*k +: 8]  <= e[7:0];
      end else begin
        bus.ipReqValid[k]        <= 1'b0;
        bus.ipReqLast[k]         <= 1'b0;
        bus.ipReqData[8*k +: 8]  <= 8'h00;
      end
    end
  end

  always @(negedge clk) begin : mon
    if ($countones(bus.opReqReady) > 1) multi_rdy <= multi_rdy + 1;
    for (int k = 0; k < 4; k++)
      if (bus.opReqReady[k]) rdy_cnt[k] <= rdy_cnt[k] + 1;
    if (bus.opTxSend && bus.ipTxBusy) send_busy <= send_busy + 1;
    if (bus.opTxSend) send_hi <= send_hi + 1;
  end

  // UART model: busy rises 2 cycles after send, lasts busy_len cycles.
  always @(posedge clk) begin : uart
    if (dly == 0 && !mb && bus.opTxSend) begin
      dly <= 2;
      cap <= bus.opTxData;
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        mb <= 1'b1;
        bc <= busy_len;
        sent.push_back(cap);
      end
    end
    if (mb) begin
      bc <= bc - 1;
      if (bc == 1) mb <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] b, input bit l);
    case (ch)
      0: q0.push_back({l, b});
      1: q1.push_back({l, b});
      2: q2.push_back({l, b});
      default: q3.push_back({l, b});
    endcase
  endtask

  task automatic expb(input int ch, input logic [7:0] b, input bit first);
`ifdef UART_TX_ARBITER_HEADER_EN
    if (first) expq.push_back({4'hA, 1'b0, 3'(ch)});
`endif
    expq.push_back(b);
  endtask

  function automatic bit all_done();
    bit d;
    d = !bus.opActive && !mb && dly == 0;
    for (int k = 0; k < 4; k++)
      if (rp[k] != qsize(k)) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input string tag, input int maxc);
    int c;
    c = 0;
    while (c < maxc && !all_done()) begin
      tick(1);
      c++;
    end
    chk({tag, "_timeout"}, 32'(c < maxc), 32'd1);
  endtask

  task automatic chk_sent(input string tag);
    logic [31:0] obs;
    chk({tag, "_count"}, 32'(sent.size() - base), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      obs = (base + i < sent.size()) ? 32'(sent[base+i]) : 32'hFFFF_FFFF;
      chk($sformatf("%s_byte%0d", tag, i), obs, 32'(expq[i]));
    end
    base = sent.size();
    expq.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  int r0, s0, c, hdr;

  initial begin
`ifdef UART_TX_ARBITER_HEADER_EN
    hdr = 1;
`else
    hdr = 0;
`endif
    rst = 1'b1;
    tick(3);
    chk("rst_grant", 32'(bus.opGrant), 32'd0);
    chk("rst_active", 32'(bus.opActive), 32'd0);
    chk("rst_send", 32'(bus.opTxSend), 32'd0);
    chk("rst_ready", 32'(bus.opReqReady), 32'd0);
    chk("rst_data", 32'(bus.opTxData), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("idle_grant", 32'(bus.opGrant), 32'd0);

    // Single channel, long UART frames
    busy_len = 100;
    r0 = rdy_cnt[1];
    s0 = send_busy;
    push(1, 8'h55, 1'b0);
    push(1, 8'hAA, 1'b1);
    expb(1, 8'h55, 1'b1);
    expb(1, 8'hAA, 1'b0);
    tick(6);
    chk("t1_grant_mid", 32'(bus.opGrant), 32'b0010);
    chk("t1_active_mid", 32'(bus.opActive), 32'd1);
    wait_done("t1", 800);
    chk_sent("t1");
    chk("t1_ready1", 32'(rdy_cnt[1] - r0), 32'd2);
    chk("t1_send_overlap", 32'(send_busy - s0), 32'(2 + hdr));
    chk("t1_grant_end", 32'(bus.opGrant), 32'd0);
    chk("t1_active_end", 32'(bus.opActive), 32'd0);

    // Simultaneous 2-byte packets on 0,2,3 from reset
    busy_len = 8;
    do_reset();
    push(0, 8'h00, 1'b0); push(0, 8'h01, 1'b1);
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b1);
    push(3, 8'h30, 1'b0); push(3, 8'h31, 1'b1);
    expb(0, 8'h00, 1'b1); expb(0, 8'h01, 1'b0);
    expb(2, 8'h20, 1'b1); expb(2, 8'h21, 1'b0);
    expb(3, 8'h30, 1'b1); expb(3, 8'h31, 1'b0);
    wait_done("t2", 600);
    chk_sent("t2");

    // Channel 0 keeps requesting; channel 1 must get a turn
    do_reset();
    r0 = rdy_cnt[1];
    push(0, 8'h40, 1'b1); push(0, 8'h41, 1'b1); push(0, 8'h42, 1'b1);
    push(1, 8'h50, 1'b1);
    expb(0, 8'h40, 1'b1); expb(1, 8'h50, 1'b1);
    expb(0, 8'h41, 1'b1); expb(0, 8'h42, 1'b1);
    wait_done("t3", 600);
    chk_sent("t3");
    chk("t3_ready1", 32'(rdy_cnt[1] - r0), 32'd1);

    // Reset released while UART still busy
    rst = 1'b1;
    busy_force = 1'b1;
    tick(2);
    push(0, 8'h77, 1'b1);
    rst = 1'b0;
    s0 = send_hi;
    tick(50);
    chk("t4_no_send", 32'(send_hi - s0), 32'd0);
    chk("t4_grant", 32'(bus.opGrant), 32'd0);
    chk("t4_active", 32'(bus.opActive), 32'd0);
    busy_force = 1'b0;
    expb(0, 8'h77, 1'b1);
    wait_done("t4", 300);
    chk_sent("t4");

    // Granted channel stalls mid-packet
    do_reset();
    r0 = rdy_cnt[2];
    s0 = rdy_cnt[0];
    push(0, 8'h11, 1'b0);
    push(2, 8'h33, 1'b1);
    c = 0;
    while (c < 60 && rdy_cnt[0] - s0 < 1) begin
      tick(1);
      c++;
    end
    chk("t5_first_timeout", 32'(c < 60), 32'd1);
    tick(40);
    chk("t5_grant_hold", 32'(bus.opGrant), 32'b0001);
    chk("t5_active_hold", 32'(bus.opActive), 32'd1);
    chk("t5_ch2_wait", 32'(rdy_cnt[2] - r0), 32'd0);
    chk("t5_sent_stall", 32'(sent.size() - base), 32'(1 + hdr));
    push(0, 8'h12, 1'b1);
    expb(0, 8'h11, 1'b1); expb(0, 8'h12, 1'b0);
    expb(2, 8'h33, 1'b1);
    wait_done("t5", 600);
    chk_sent("t5");

    // Reset during SEND
    do_reset();
    push(1, 8'h5A, 1'b1);
    c = 0;
    while (c < 40 && !bus.opTxSend) begin
      tick(1);
      c++;
    end
    chk("t6_send_timeout", 32'(c < 40), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_send_rst", 32'(bus.opTxSend), 32'd0);
    chk("t6_grant_rst", 32'(bus.opGrant), 32'd0);
    chk("t6_active_rst", 32'(bus.opActive), 32'd0);
    push(3, 8'h3C, 1'b1);
    push(0, 8'h0C, 1'b1);
    c = 0;
    while (c < 300 && (mb || dly != 0)) begin
      tick(1);
      c++;
    end
    chk("t6_uart_timeout", 32'(c < 300), 32'd1);
    base = sent.size();
    tick(2);
    rst = 1'b0;
    expb(0, 8'h0C, 1'b1);
    expb(3, 8'h3C, 1'b1);
    wait_done("t6", 600);
    chk_sent("t6");

    // Single-byte packet on channel 2 (header when enabled)
    do_reset();
    r0 = rdy_cnt[2];
    push(2, 8'h31, 1'b1);
    expb(2, 8'h31, 1'b1);
    wait_done("t7", 300);
    chk_sent("t7");
    chk("t7_ready2", 32'(rdy_cnt[2] - r0), 32'd1);

    chk("one_hot_ready", 32'(multi_rdy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
